// File: rtl/util_axis_puf_arbiter.sv
// Round-robin AXIS arbiter sharing one PUF controller among NUM_REQ requesters.
// Responses are routed back in order using a FIFO of granted requester IDs.
module util_axis_puf_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int TAG_DEPTH = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic [8*NUM_REQ-1:0]   s_axis_tdata,
    input  logic [4*NUM_REQ-1:0]   s_axis_tuser,
    input  logic [NUM_REQ-1:0]     s_axis_tvalid,
    input  logic [NUM_REQ-1:0]     s_axis_tlast,
    output logic [NUM_REQ-1:0]     s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic [3:0]             m_axis_tuser,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    input  logic [7:0]             s_rsp_tdata,
    input  logic                   s_rsp_tvalid,
    input  logic                   s_rsp_tlast,
    output logic                   s_rsp_tready,
    output logic [7:0]             m_rsp_tdata,
    output logic [NUM_REQ-1:0]     m_rsp_tvalid,
    output logic                   m_rsp_tlast,
    input  logic [NUM_REQ-1:0]     m_rsp_tready,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] w_sel;
    logic           w_any;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_last_beat;
    logic           w_gvalid;
    logic           w_glast;
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;
    logic [IDW-1:0] r_tag [TAG_DEPTH];
    logic [IDW-1:0] w_head;

    // Lowest offset from rr_ptr wins: scan downward so the last hit is kept.
    always_comb begin
        w_sel = r_rr_ptr;
        w_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_axis_tvalid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_sel = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_gvalid = s_axis_tvalid[r_grant_id];
    assign w_glast  = s_axis_tlast[r_grant_id];

    always_comb begin
        w_next        = r_state;
        w_push        = 1'b0;
        w_last_beat   = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any && !w_full) begin
                    w_next = XFER;
                    w_push = 1'b1;
                end
            end
            XFER: begin
                m_axis_tdata  = s_axis_tdata[8*int'(r_grant_id) +: 8];
                m_axis_tuser  = s_axis_tuser[4*int'(r_grant_id) +: 4];
                m_axis_tvalid = w_gvalid;
                m_axis_tlast  = w_glast;
                s_axis_tready[r_grant_id] = m_axis_tready;
                if (w_gvalid && w_glast && m_axis_tready) begin
                    w_last_beat = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            if (w_push) begin
                r_grant_id <= w_sel;
            end
            if (w_last_beat) begin
                r_rr_ptr <= (r_grant_id == IDW'(NUM_REQ - 1)) ?
                            '0 : r_grant_id + 1'b1;
            end
        end
    end

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr == r_rd);
    assign w_full  = ((r_wr ^ r_rd) == {1'b1, {AW{1'b0}}});
    assign w_head  = r_tag[r_rd[AW-1:0]];
    assign w_pop   = !w_empty && s_rsp_tvalid && s_rsp_tready && s_rsp_tlast;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_tag[r_wr[AW-1:0]] <= w_sel;
        end
    end

    always_comb begin
        m_rsp_tvalid = '0;
        s_rsp_tready = 1'b0;
        if (!w_empty) begin
            m_rsp_tvalid[w_head] = s_rsp_tvalid;
            s_rsp_tready         = m_rsp_tready[w_head];
        end
    end

    assign m_rsp_tdata = s_rsp_tdata;
    assign m_rsp_tlast = s_rsp_tlast;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == XFER) || !w_empty;

endmodule

// File: tb/tb_util_axis_puf_arbiter.sv
// Bench for util_axis_puf_arbiter: per-requester packet queues, a
// round-robin grant model and an in-order tag queue predict every output.
module tb_util_axis_puf_arbiter;

    localparam int N = 4;

    logic           aclk = 1'b0;
    logic           arst = 1'b0;
    logic [8*N-1:0] s_axis_tdata  = '0;
    logic [4*N-1:0] s_axis_tuser  = '0;
    logic [N-1:0]   s_axis_tvalid = '0;
    logic [N-1:0]   s_axis_tlast  = '0;
    logic [N-1:0]   s_axis_tready;
    logic [7:0]     m_axis_tdata;
    logic [3:0]     m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready = 1'b0;
    logic [7:0]     s_rsp_tdata   = '0;
    logic           s_rsp_tvalid  = 1'b0;
    logic           s_rsp_tlast   = 1'b0;
    logic           s_rsp_tready;
    logic [7:0]     m_rsp_tdata;
    logic [N-1:0]   m_rsp_tvalid;
    logic           m_rsp_tlast;
    logic [N-1:0]   m_rsp_tready  = '0;
    logic [1:0]     grant_id;
    logic           busy;

    util_axis_puf_arbiter #(.NUM_REQ(N), .TAG_DEPTH(4)) dut (
        .aclk(aclk), .arst(arst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .s_rsp_tdata(s_rsp_tdata), .s_rsp_tvalid(s_rsp_tvalid),
        .s_rsp_tlast(s_rsp_tlast), .s_rsp_tready(s_rsp_tready),
        .m_rsp_tdata(m_rsp_tdata), .m_rsp_tvalid(m_rsp_tvalid),
        .m_rsp_tlast(m_rsp_tlast), .m_rsp_tready(m_rsp_tready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Beat = {last, user[3:0], data[7:0]}
    logic [12:0] bq [N][$];
    int          tagq [$];
    int          rr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input int base);
        logic [7:0] d;
        logic [3:0] u;
        for (int b = 0; b < len; b++) begin
            d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + b);
            u = 4'($urandom_range(0, 15));
            bq[r].push_back({(b == len - 1), u, d});
        end
    endtask

    task automatic drive_s();
        logic [12:0] h;
        for (int r = 0; r < N; r++) begin
            h = (bq[r].size() > 0) ? bq[r][0] : 13'd0;
            s_axis_tvalid[r]        = (bq[r].size() > 0);
            s_axis_tlast[r]         = h[12];
            s_axis_tuser[4*r +: 4]  = h[11:8];
            s_axis_tdata[8*r +: 8]  = h[7:0];
        end
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < N; i++) begin
            if (bq[(rr + i) % N].size() > 0) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < N; r++) bq[r].delete();
        tagq.delete();
        rr = 0;
    endtask

    task automatic run_packets(input int n, input bit resp, input bit gapchk);
        int          done;
        int          owner;
        int          cyc;
        int          last_cyc;
        bit          first_pkt;
        logic [12:0] eb;
        logic [7:0]  rd;
        done = 0; owner = -1; cyc = 0; last_cyc = 0; first_pkt = 1; rd = '0;
        while ((done < n || (resp && tagq.size() > 0)) && cyc < 2000) begin
            @(posedge aclk); #1;
            cyc++;
            drive_s();
            m_axis_tready = 1'b1;
            m_rsp_tready  = '1;
            if (resp && tagq.size() > 0) begin
                rd = 8'($urandom);
                s_rsp_tdata  = rd;
                s_rsp_tvalid = 1'b1;
                s_rsp_tlast  = 1'b1;
            end else begin
                s_rsp_tvalid = 1'b0;
                s_rsp_tlast  = 1'b0;
            end
            #1;
            if (s_rsp_tvalid) begin
                chk("rsp_route", m_rsp_tvalid, 1 << tagq[0]);
                chk("rsp_data", m_rsp_tdata, rd);
                chk("rsp_ready", s_rsp_tready, 1);
                void'(tagq.pop_front());
            end
            if (m_axis_tvalid) begin
                if (owner < 0) begin
                    owner = rr_pick();
                    if (gapchk && !first_pkt) chk("bubble", cyc - last_cyc, 2);
                    first_pkt = 0;
                    if (owner >= 0) tagq.push_back(owner);
                end
                if (owner < 0) begin
                    chk("spurious_valid", m_axis_tvalid, 0);
                end else begin
                    eb = bq[owner][0];
                    chk("m_axis_beat", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, eb);
                    chk("grant_id", grant_id, owner);
                    chk("s_tready", s_axis_tready, 1 << owner);
                    void'(bq[owner].pop_front());
                    if (eb[12]) begin
                        rr = (owner + 1) % N;
                        owner = -1;
                        done++;
                        last_cyc = cyc;
                    end
                end
            end else begin
                chk("tready_idle", s_axis_tready, 0);
            end
        end
        if (cyc >= 2000) chk("run_timeout", 1, 0);
        @(posedge aclk); #1;
        drive_s();
        s_rsp_tvalid = 1'b0;
        s_rsp_tlast  = 1'b0;
    endtask

    task automatic rsp_beat(input bit last);
        logic [7:0] d;
        logic [3:0] rdy;
        int         h;
        int         k;
        bit         acc;
        d = 8'($urandom); k = 0; acc = 0;
        h = (tagq.size() > 0) ? tagq[0] : 0;
        while (!acc && k < 50) begin
            @(posedge aclk); #1;
            k++;
            rdy = 4'($urandom);
            if (k == 1) rdy[h] = 1'b0;
            s_rsp_tvalid = 1'b1;
            s_rsp_tdata  = d;
            s_rsp_tlast  = last;
            m_rsp_tready = rdy;
            #1;
            chk("rsp_onehot", m_rsp_tvalid, 1 << h);
            chk("rsp_stall_ready", s_rsp_tready, rdy[h]);
            chk("rsp_last", m_rsp_tlast, last);
            acc = rdy[h];
        end
        if (!acc) chk("rsp_timeout", 1, 0);
        if (last && tagq.size() > 0) void'(tagq.pop_front());
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_s_tready"}, s_axis_tready, 0);
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_rsp_tvalid"}, m_rsp_tvalid, 0);
        chk({tag, "_rsp_tready"}, s_rsp_tready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant_id, 0);
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        arst = 1'b1;
        #2;
        check_quiet("rst");
        @(posedge aclk); #1;
        arst = 1'b0;
        clear_model();
        drive_s();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset release, no traffic
        #1 arst = 1'b1;
        #2;
        check_quiet("por");
        repeat (2) @(posedge aclk);
        #1 arst = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check_quiet("idle");

        // Two 3-beat packets, req0 then req2, one bubble between
        add_pkt(0, 3, 8'h10);
        add_pkt(2, 3, -1);
        run_packets(2, 1, 1);
        chk("drained_busy", busy, 0);

        // All requesters busy, single-beat packets, strict rotation
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) add_pkt(r, 1, -1);
        run_packets(8, 1, 1);

        // Random-length traffic on random requesters
        for (int p = 0; p < 12; p++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), -1);
        run_packets(12, 1, 0);

        // Tag FIFO full blocks the fifth packet
        for (int p = 0; p < 5; p++) add_pkt(1, 1, -1);
        run_packets(4, 0, 0);
        repeat (4) begin
            @(posedge aclk); #2;
            chk("full_tready", s_axis_tready, 0);
            chk("full_mvalid", m_axis_tvalid, 0);
            chk("full_busy", busy, 1);
        end
        rsp_beat(1'b1);
        run_packets(1, 1, 0);
        chk("after_full_busy", busy, 0);

        // Two-beat responses routed to req3 then req0 with stalls
        add_pkt(3, $urandom_range(1, 3), -1);
        add_pkt(0, $urandom_range(1, 3), -1);
        run_packets(2, 0, 0);
        repeat (2) begin
            rsp_beat(1'b0);
            rsp_beat(1'b1);
        end
        @(posedge aclk); #1;
        s_rsp_tvalid = 1'b0;
        #1;
        chk("rsp_done_busy", busy, 0);

        // Reset mid-packet with two tags outstanding
        add_pkt(1, 1, -1);
        add_pkt(1, 1, -1);
        run_packets(2, 0, 0);
        add_pkt(2, 3, -1);
        @(posedge aclk); #1;
        drive_s();
        @(posedge aclk); #2;
        chk("mid_pkt_valid", m_axis_tvalid, 1);
        s_rsp_tvalid = 1'b1;
        s_rsp_tlast  = 1'b1;
        m_rsp_tready = '1;
        arst = 1'b1;
        #1;
        check_quiet("async_rst");
        @(posedge aclk); #1;
        arst = 1'b0;
        clear_model();
        s_rsp_tvalid = 1'b0;
        s_rsp_tlast  = 1'b0;
        drive_s();
        add_pkt(3, 1, -1);
        add_pkt(1, 2, -1);
        add_pkt(0, 2, -1);
        run_packets(3, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
